dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the vector CPU load/store port and the
//  VGA scan-out fetcher. Grants one access per cycle, routes 1-cycle-latency read data

---
 rtl/dmem_arbiter.sv | 116 +++++++++++
 tb/tb_dmem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the vector CPU load/store port and the VGA fetcher.
// One access per cycle; 1-cycle read return is routed to the owner recorded at grant time.
module dmem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned VGA_PRIO     = 1,
  parameter int unsigned CPU_MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   conflict_cnt
);

  localparam int unsigned WW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WW-1:0] MaxWait = WW'(CPU_MAX_WAIT);

  typedef enum logic {WinVga, WinCpu} winner_e;

  logic [WW-1:0] wait_q, wait_d;
  winner_e       last_q, last_d;
  logic          cpu_rv_q, cpu_rv_d;
  logic          vga_rv_q, vga_rv_d;
  logic [15:0]   conflict_q, conflict_d;
  logic          conflict;
  logic          cpu_win;

  assign conflict = cpu_req && vga_req;

  always_comb begin
    cpu_win = cpu_req;
    if (conflict) begin
      if (VGA_PRIO != 0) begin
        // Starvation guard: CPU forced through after losing MaxWait conflicts in a row.
        cpu_win = (wait_q == MaxWait);
      end else begin
        cpu_win = (last_q == WinVga);
      end
    end
  end

  always_comb begin
    cpu_gnt   = cpu_win && !reset;
    vga_gnt   = vga_req && !cpu_win && !reset;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_we ? cpu_wdata : '0;
    end else if (vga_gnt) begin
      mem_addr = vga_addr;
    end
  end

  always_comb begin
    wait_d     = wait_q;
    last_d     = last_q;
    conflict_d = conflict_q;
    cpu_rv_d   = cpu_gnt && !cpu_we;
    vga_rv_d   = vga_gnt;
    if (!cpu_req || cpu_gnt) begin
      wait_d = '0;
    end else if (wait_q != MaxWait) begin
      wait_d = wait_q + WW'(1);
    end
    if (cpu_gnt) begin
      last_d = WinCpu;
    end else if (vga_gnt) begin
      last_d = WinVga;
    end
    if (conflict && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q     <= '0;
      last_q     <= WinVga;
      cpu_rv_q   <= 1'b0;
      vga_rv_q   <= 1'b0;
      conflict_q <= '0;
    end else begin
      wait_q     <= wait_d;
      last_q     <= last_d;
      cpu_rv_q   <= cpu_rv_d;
      vga_rv_q   <= vga_rv_d;
      conflict_q <= conflict_d;
    end
  end

  // Return flags are masked during reset so an in-flight read is dropped.
  assign cpu_rvalid   = cpu_rv_q && !reset;
  assign vga_rvalid   = vga_rv_q && !reset;
  assign cpu_rdata    = cpu_rvalid ? mem_rdata : '0;
  assign vga_rdata    = vga_rvalid ? mem_rdata : '0;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: instance 0 uses VGA priority with starvation guard, instance 1
// round-robin; both share stimulus and are checked against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int MaxWait = 4;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, vga_req;
  logic [31:0] cpu_addr, cpu_wdata, vga_addr;

  logic        cpu_gnt [2];
  logic        cpu_rvalid [2];
  logic [31:0] cpu_rdata [2];
  logic        vga_gnt [2];
  logic        vga_rvalid [2];
  logic [31:0] vga_rdata [2];
  logic [31:0] mem_addr [2];
  logic        mem_we [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [15:0] conflict_cnt [2];

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.AW(32), .DW(32), .VGA_PRIO(1), .CPU_MAX_WAIT(MaxWait)) u_dut_prio (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt[0]), .cpu_rvalid(cpu_rvalid[0]), .cpu_rdata(cpu_rdata[0]),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt[0]), .vga_rvalid(vga_rvalid[0]), .vga_rdata(vga_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .conflict_cnt(conflict_cnt[0])
  );

  dmem_arbiter #(.AW(32), .DW(32), .VGA_PRIO(0), .CPU_MAX_WAIT(MaxWait)) u_dut_rr (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt[1]), .cpu_rvalid(cpu_rvalid[1]), .cpu_rdata(cpu_rdata[1]),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt[1]), .vga_rvalid(vga_rvalid[1]), .vga_rdata(vga_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .conflict_cnt(conflict_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous-read memories attached to each instance.
  bit [31:0] env_mem [2][256];
  bit        env_init = 1'b0;
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 256; i++) begin
        env_mem[0][i] <= init_word(i);
        env_mem[1][i] <= init_word(i);
      end
      env_init <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (mem_we[d]) env_mem[d][mem_addr[d][7:0]] <= mem_wdata[d];
        mem_rdata[d] <= env_mem[d][mem_addr[d][7:0]];
      end
    end
  end

  // Reference model state.
  bit [31:0] mdl_mem [2][256];
  int        m_wait [2];
  bit        m_last_cpu [2];
  int        m_cnt [2];
  bit        m_pend_cpu [2];
  bit        m_pend_vga [2];
  logic [31:0] m_pend_data [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Check one cycle against the model at the negedge, then advance model and clock.
  task automatic step();
    bit          ecpu, evga, erv_c, erv_v;
    logic [31:0] ea, ewd;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        ecpu = 1'b0;
        evga = 1'b0;
      end else if (cpu_req && vga_req) begin
        ecpu = (d == 0) ? (m_wait[d] >= MaxWait) : !m_last_cpu[d];
        evga = !ecpu;
      end else begin
        ecpu = cpu_req;
        evga = vga_req;
      end
      ea    = ecpu ? cpu_addr : (evga ? vga_addr : 32'h0);
      ewd   = (ecpu && cpu_we) ? cpu_wdata : 32'h0;
      erv_c = !reset && m_pend_cpu[d];
      erv_v = !reset && m_pend_vga[d];
      check_eq($sformatf("d%0d_cpu_gnt", d), 64'(cpu_gnt[d]), 64'(ecpu));
      check_eq($sformatf("d%0d_vga_gnt", d), 64'(vga_gnt[d]), 64'(evga));
      check_eq($sformatf("d%0d_mem_addr", d), 64'(mem_addr[d]), 64'(ea));
      check_eq($sformatf("d%0d_mem_we", d), 64'(mem_we[d]), 64'(ecpu && cpu_we));
      check_eq($sformatf("d%0d_mem_wdata", d), 64'(mem_wdata[d]), 64'(ewd));
      check_eq($sformatf("d%0d_cpu_rvalid", d), 64'(cpu_rvalid[d]), 64'(erv_c));
      check_eq($sformatf("d%0d_cpu_rdata", d), 64'(cpu_rdata[d]),
               erv_c ? 64'(m_pend_data[d]) : 64'h0);
      check_eq($sformatf("d%0d_vga_rvalid", d), 64'(vga_rvalid[d]), 64'(erv_v));
      check_eq($sformatf("d%0d_vga_rdata", d), 64'(vga_rdata[d]),
               erv_v ? 64'(m_pend_data[d]) : 64'h0);
      check_eq($sformatf("d%0d_conflict_cnt", d), 64'(conflict_cnt[d]), 64'(m_cnt[d]));
      if (reset) begin
        m_wait[d]     = 0;
        m_last_cpu[d] = 1'b0;
        m_cnt[d]      = 0;
        m_pend_cpu[d] = 1'b0;
        m_pend_vga[d] = 1'b0;
      end else begin
        m_pend_data[d] = mdl_mem[d][ea[7:0]];
        m_pend_cpu[d]  = ecpu && !cpu_we;
        m_pend_vga[d]  = evga;
        if (ecpu && cpu_we) mdl_mem[d][cpu_addr[7:0]] = cpu_wdata;
        if (!cpu_req || ecpu) m_wait[d] = 0;
        else if (m_wait[d] < MaxWait) m_wait[d]++;
        if (ecpu) m_last_cpu[d] = 1'b1;
        else if (evga) m_last_cpu[d] = 1'b0;
        if (cpu_req && vga_req && m_cnt[d] < 65535) m_cnt[d]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rst, input bit creq, input bit cwe, input logic [31:0] ca,
                       input logic [31:0] cwd, input bit vreq, input logic [31:0] va);
    reset     = rst;
    cpu_req   = creq;
    cpu_we    = cwe;
    cpu_addr  = ca;
    cpu_wdata = cwd;
    vga_req   = vreq;
    vga_addr  = va;
    #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) mdl_mem[d][i] = init_word(i);
      m_wait[d] = 0; m_last_cpu[d] = 1'b0; m_cnt[d] = 0;
      m_pend_cpu[d] = 1'b0; m_pend_vga[d] = 1'b0; m_pend_data[d] = 32'h0;
    end
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 32'h8);

    // Reset with both requests held.
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_cpu_gnt", 64'(cpu_gnt[0]), 64'h0);
      check_eq("rst_vga_gnt", 64'(vga_gnt[0]), 64'h0);
      check_eq("rst_mem_we", 64'(mem_we[0]), 64'h0);
      check_eq("rst_cpu_rvalid", 64'(cpu_rvalid[0]), 64'h0);
      check_eq("rst_vga_rvalid", 64'(vga_rvalid[0]), 64'h0);
    end
    check_eq("rst_cnt", 64'(conflict_cnt[0]), 64'h0);

    // CPU write then read-back.
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    check_eq("wr_cpu_gnt", 64'(cpu_gnt[0]), 64'h1);
    check_eq("wr_mem_we", 64'(mem_we[0]), 64'h1);
    check_eq("wr_mem_addr", 64'(mem_addr[0]), 64'h10);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    check_eq("rd_cpu_gnt", 64'(cpu_gnt[0]), 64'h1);
    check_eq("wr_no_rvalid", 64'(cpu_rvalid[0]), 64'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("rd_cpu_rvalid", 64'(cpu_rvalid[0]), 64'h1);
    check_eq("rd_cpu_rdata", 64'(cpu_rdata[0]), 64'hDEAD_BEEF);
    step();

    // Continuous conflict from a fresh reset: priority pattern and round-robin pattern.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 32'h40);
      check_eq("prio_cpu_gnt", 64'(cpu_gnt[0]), 64'((i % 5) == 4));
      check_eq("rr_cpu_gnt", 64'(cpu_gnt[1]), 64'((i % 2) == 0));
      check_eq("prio_cnt", 64'(conflict_cnt[0]), 64'(i));
      step();
    end

    // Interleaved VGA then CPU reads.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h20);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h0);
    check_eq("il_vga_rvalid", 64'(vga_rvalid[0]), 64'h1);
    check_eq("il_vga_rdata", 64'(vga_rdata[0]), 64'(mdl_mem[0][8'h20]));
    check_eq("il_cpu_rvalid0", 64'(cpu_rvalid[0]), 64'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("il_cpu_rvalid", 64'(cpu_rvalid[0]), 64'h1);
    check_eq("il_cpu_rdata", 64'(cpu_rdata[0]), 64'(mdl_mem[0][8'h24]));
    check_eq("il_vga_rvalid0", 64'(vga_rvalid[0]), 64'h0);
    step();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom),
            {22'h0, 8'($urandom_range(0, 63)), 2'b00}, $urandom, 1'($urandom),
            {22'h0, 8'($urandom_range(0, 63)), 2'b00});
      step();
    end

    // Reset right after a CPU read grant drops the return.
    drive(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("rstdrop_rvalid0", 64'(cpu_rvalid[0]), 64'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("rstdrop_rvalid1", 64'(cpu_rvalid[0]), 64'h0);
    step();

    // Conflict counter saturation.
    drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'hC);
    for (int i = 0; i < 65540; i++) step();
    check_eq("sat_cnt_prio", 64'(conflict_cnt[0]), 64'hFFFF);
    check_eq("sat_cnt_rr", 64'(conflict_cnt[1]), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
